uram_wght_sched: RTL and testbench

- Single-clock scheduler in front of one dual-port URAM weight bank (one write port, one registered read port).
- Shares the read port among NREQ neuron-core requesters using round-robin arbitration.
- Sequences bulk weight loads from a streaming loader into a contiguous, wrapping address range.
- Tags every returned read word with the requester index so cores can demux the shared return bus.

---
 rtl/uram_wght_sched_if.sv | 46 ++++
 rtl/uram_wght_sched.sv | 151 +++++++++++++++
 tb/tb_uram_wght_sched.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uram_wght_sched_if.sv
// Signal bundle between the weight scheduler, its read requesters, the bulk
// loader and the URAM bank ports.
interface uram_wght_sched_if #(
    parameter int BIT_WIDTH = 31,
    parameter int RAM_DEPTH = 32,
    parameter int AW        = $clog2(RAM_DEPTH),
    parameter int NREQ      = 4,
    parameter int IDW       = $clog2(NREQ)
);
    logic [NREQ-1:0]      rd_req;
    logic [NREQ*AW-1:0]   rd_addr;
    logic [NREQ-1:0]      rd_gnt;
    logic                 rd_vld;
    logic [IDW-1:0]       rd_id;
    logic [BIT_WIDTH:0]   rd_dat;

    logic                 ld_start;
    logic [AW-1:0]        ld_base;
    logic [AW:0]          ld_len;
    logic                 ld_dat_vld;
    logic [BIT_WIDTH:0]   ld_dat;
    logic                 ld_dat_rdy;
    logic                 ld_busy;
    logic                 ld_done;

    logic                 ram_ren;
    logic [AW-1:0]        ram_raddr;
    logic [BIT_WIDTH:0]   ram_rdat;
    logic                 ram_wren;
    logic [AW-1:0]        ram_wraddr;
    logic [BIT_WIDTH:0]   ram_wrdat;

    // scheduler view
    modport slave (
        input  rd_req, rd_addr, ld_start, ld_base, ld_len, ld_dat_vld, ld_dat, ram_rdat,
        output rd_gnt, rd_vld, rd_id, rd_dat, ld_dat_rdy, ld_busy, ld_done,
               ram_ren, ram_raddr, ram_wren, ram_wraddr, ram_wrdat
    );

    // requester / loader / RAM view
    modport master (
        output rd_req, rd_addr, ld_start, ld_base, ld_len, ld_dat_vld, ld_dat, ram_rdat,
        input  rd_gnt, rd_vld, rd_id, rd_dat, ld_dat_rdy, ld_busy, ld_done,
               ram_ren, ram_raddr, ram_wren, ram_wraddr, ram_wrdat
    );
endinterface

// File: rtl/uram_wght_sched.sv
// Weight-bank scheduler: round-robin read arbitration across neuron cores,
// bulk load sequencing into a wrapping address range, and ID-tagged returns.
//
// state  | meaning
// S_IDLE | waiting for ld_start
// S_LOAD | accepting loader beats, one write per beat
// S_DONE | one-cycle ld_done pulse, then back to idle
module uram_wght_sched #(
    parameter int BIT_WIDTH = 31,
    parameter int RAM_DEPTH = 32,
    parameter int AW        = $clog2(RAM_DEPTH),
    parameter int NREQ      = 4,
    parameter int IDW       = $clog2(NREQ),
    parameter int RD_LAT    = 1
) (
    input logic             clk,
    input logic             rst_n,
    uram_wght_sched_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t             r_state;
    logic [AW-1:0]      r_waddr;
    logic [AW:0]        r_remain;
    logic               r_busy;
    logic               r_done;
    logic [IDW-1:0]     r_ptr;
    logic [RD_LAT-1:0]  r_vld_sr;
    logic [IDW-1:0]     r_id_sr [RD_LAT];

    logic               w_beat;
    logic [NREQ-1:0]    w_elig;
    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [NREQ-1:0]    w_gnt;
    logic [AW-1:0]      w_raddr;

    assign w_beat         = r_busy & bus.ld_dat_vld;
    assign bus.ram_wren   = w_beat;
    assign bus.ram_wraddr = r_waddr;
    assign bus.ram_wrdat  = bus.ld_dat;
    assign bus.ld_dat_rdy = r_busy;
    assign bus.ld_busy    = r_busy;
    assign bus.ld_done    = r_done;

    // Eligibility with write-collision stall, then round-robin pick starting after r_ptr.
    // Gated by rst_n so grants are silent while reset is held.
    always_comb begin
        w_elig  = '0;
        w_found = 1'b0;
        w_win   = '0;
        w_gnt   = '0;
        w_raddr = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = bus.rd_req[i] & rst_n &
                        ~(w_beat & (bus.rd_addr[i*AW +: AW] == r_waddr));
        end
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && w_elig[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
        if (w_found) begin
            w_gnt   = NREQ'(1) << w_win;
            w_raddr = bus.rd_addr[int'(w_win)*AW +: AW];
        end
    end

    assign bus.rd_gnt    = w_gnt;
    assign bus.ram_ren   = w_found;
    assign bus.ram_raddr = w_raddr;

    // Load sequencer with registered busy/done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_waddr  <= '0;
            r_remain <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.ld_start) begin
                        if (bus.ld_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_waddr  <= bus.ld_base;
                            r_remain <= bus.ld_len;
                            r_busy   <= 1'b1;
                            r_state  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        r_waddr  <= (r_waddr == AW'(RAM_DEPTH - 1)) ? '0 : r_waddr + AW'(1);
                        r_remain <= r_remain - (AW+1)'(1);
                        if (r_remain == (AW+1)'(1)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Round-robin pointer follows the last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDW'(NREQ - 1);
        end else if (w_found) begin
            r_ptr <= w_win;
        end
    end

    // Valid/ID shift register matching the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_sr <= '0;
            for (int k = 0; k < RD_LAT; k++) r_id_sr[k] <= '0;
        end else begin
            r_vld_sr[0] <= w_found;
            r_id_sr[0]  <= w_win;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld_sr[k] <= r_vld_sr[k-1];
                r_id_sr[k]  <= r_id_sr[k-1];
            end
        end
    end

    assign bus.rd_vld = r_vld_sr[RD_LAT-1];
    assign bus.rd_id  = r_id_sr[RD_LAT-1];
    assign bus.rd_dat = bus.ram_rdat;

endmodule

// File: tb/tb_uram_wght_sched.sv
// Directed bench for uram_wght_sched with an abstract per-cycle model.
module tb_uram_wght_sched;
    localparam int BIT_WIDTH = 31;
    localparam int RAM_DEPTH = 32;
    localparam int AW        = 5;
    localparam int NREQ      = 4;
    localparam int IDW       = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uram_wght_sched_if #(.BIT_WIDTH(BIT_WIDTH), .RAM_DEPTH(RAM_DEPTH), .AW(AW),
                         .NREQ(NREQ), .IDW(IDW)) bus ();

    uram_wght_sched #(.BIT_WIDTH(BIT_WIDTH), .RAM_DEPTH(RAM_DEPTH), .AW(AW),
                      .NREQ(NREQ), .IDW(IDW), .RD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string name, input logic [31:0] act[$], input logic [31:0] exp[$]);
        chk({name, "_len"}, 32'(act.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            chk(name, act[i], exp[i]);
    endtask

    // Environment RAM: one write port, one registered read port.
    logic [31:0] ram_mem [RAM_DEPTH];
    always @(posedge clk) begin
        if (bus.ram_wren) ram_mem[bus.ram_wraddr] <= bus.ram_wrdat;
        if (bus.ram_ren)  bus.ram_rdat <= ram_mem[bus.ram_raddr];
    end

    // Abstract model state
    logic [31:0] m_mem [RAM_DEPTH];
    int          m_wq[$];          // addresses still to be written by the current load
    bit          m_loading, m_done, m_ret_vld, next_done;
    int          m_ptr, m_ret_id;
    logic [31:0] m_ret_dat;
    bit          e_wren, e_found;
    int          e_win, e_wa;
    logic [NREQ-1:0] e_elig;

    // Logs of observed DUT activity
    logic [31:0] wlog[$], wdlog[$], glog[$], rid_log[$], rdat_log[$], e[$];
    int          n_busy, n_done, cyc, last_wcyc, done_cyc;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_ld_busy", bus.ld_busy, 0);
            chk("rst_ld_done", bus.ld_done, 0);
            chk("rst_ld_dat_rdy", bus.ld_dat_rdy, 0);
            chk("rst_rd_gnt", bus.rd_gnt, 0);
            chk("rst_rd_vld", bus.rd_vld, 0);
            chk("rst_ram_ren", bus.ram_ren, 0);
            chk("rst_ram_wren", bus.ram_wren, 0);
            m_wq.delete();
            m_loading = 0; m_done = 0; m_ret_vld = 0; m_ptr = NREQ - 1;
        end else begin
            e_wren = m_loading && bus.ld_dat_vld;
            e_wa   = e_wren ? m_wq[0] : 0;
            for (int i = 0; i < NREQ; i++)
                e_elig[i] = bus.rd_req[i] && !(e_wren && int'(bus.rd_addr[i*AW +: AW]) == e_wa);
            e_found = 0; e_win = 0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!e_found && e_elig[(m_ptr + k) % NREQ]) begin
                    e_found = 1;
                    e_win   = (m_ptr + k) % NREQ;
                end
            end

            chk("ld_busy", bus.ld_busy, m_loading);
            chk("ld_dat_rdy", bus.ld_dat_rdy, m_loading);
            chk("ld_done", bus.ld_done, m_done);
            chk("ram_wren", bus.ram_wren, e_wren);
            if (e_wren) begin
                chk("ram_wraddr", bus.ram_wraddr, e_wa);
                chk("ram_wrdat", bus.ram_wrdat, bus.ld_dat);
            end
            chk("rd_gnt", bus.rd_gnt, e_found ? (32'd1 << e_win) : 32'd0);
            chk("ram_ren", bus.ram_ren, e_found);
            if (e_found) chk("ram_raddr", bus.ram_raddr, bus.rd_addr[e_win*AW +: AW]);
            chk("rd_vld", bus.rd_vld, m_ret_vld);
            if (m_ret_vld) begin
                chk("rd_id", bus.rd_id, m_ret_id);
                chk("rd_dat", bus.rd_dat, m_ret_dat);
            end

            if (bus.ram_wren) begin wlog.push_back(bus.ram_wraddr); wdlog.push_back(bus.ram_wrdat); last_wcyc = cyc; end
            for (int i = 0; i < NREQ; i++) if (bus.rd_gnt[i]) glog.push_back(i);
            if (bus.rd_vld) begin rid_log.push_back(bus.rd_id); rdat_log.push_back(bus.rd_dat); end
            if (bus.ld_busy) n_busy++;
            if (bus.ld_done) begin n_done++; done_cyc = cyc; end

            m_ret_vld = e_found;
            m_ret_id  = e_win;
            m_ret_dat = e_found ? m_mem[bus.rd_addr[e_win*AW +: AW]] : 32'd0;
            if (e_found) m_ptr = e_win;
            next_done = 0;
            if (e_wren) begin
                m_mem[e_wa] = bus.ld_dat;
                void'(m_wq.pop_front());
                if (m_wq.size() == 0) begin m_loading = 0; next_done = 1; end
            end else if (!m_loading && !m_done && bus.ld_start) begin
                if (bus.ld_len == 0) next_done = 1;
                else begin
                    for (int k = 0; k < int'(bus.ld_len); k++)
                        m_wq.push_back((int'(bus.ld_base) + k) % RAM_DEPTH);
                    m_loading = 1;
                end
            end
            m_done = next_done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_logs();
        wlog.delete(); wdlog.delete(); glog.delete(); rid_log.delete(); rdat_log.delete();
        n_busy = 0; n_done = 0;
    endtask

    task automatic start_load(input int base, input int len);
        bus.ld_start = 1; bus.ld_base = AW'(base); bus.ld_len = (AW+1)'(len);
        step();
        bus.ld_start = 0;
    endtask

    int done_before;

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) begin
            ram_mem[i] = 32'hA000_0000 + i;
            m_mem[i]   = 32'hA000_0000 + i;
        end
        bus.ram_rdat = '0;
        bus.rd_req = '0; bus.rd_addr = '0;
        bus.ld_start = 0; bus.ld_base = '0; bus.ld_len = '0;
        bus.ld_dat_vld = 0; bus.ld_dat = '0;
        step(); step(); step();
        rst_n = 1;
        step();
        chk("post_rst_busy", bus.ld_busy, 0);
        chk("post_rst_vld", bus.rd_vld, 0);

        // Load 3 words at 5..7
        clr_logs();
        start_load(5, 3);
        bus.ld_dat_vld = 1; bus.ld_dat = 32'h0000_00AA; step();
        bus.ld_dat = 32'h0000_00BB; step();
        bus.ld_dat = 32'h0000_00CC; step();
        bus.ld_dat_vld = 0; step(); step();
        e = '{32'd5, 32'd6, 32'd7};                    chk_q("load_waddr", wlog, e);
        e = '{32'hAA, 32'hBB, 32'hCC};                 chk_q("load_wdat", wdlog, e);
        chk("load_busy_cycles", n_busy, 3);
        chk("load_done_count", n_done, 1);
        chk("load_done_delay", done_cyc - last_wcyc, 1);
        chk("model_mem6", m_mem[6], 32'hBB);

        // All four requesters, addresses 1..4
        clr_logs();
        bus.rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
        bus.rd_req  = 4'hF;
        repeat (5) step();
        bus.rd_req = 4'h0;
        step(); step();
        e = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};      chk_q("rr_order", glog, e);
        chk_q("rr_ret_id", rid_log, e);
        e = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004, 32'hA000_0001};
        chk_q("rr_ret_dat", rdat_log, e);

        // Wrapping load, then zero-length load
        clr_logs();
        start_load(30, 4);
        bus.ld_dat_vld = 1;
        for (int k = 0; k < 4; k++) begin bus.ld_dat = 32'hC0DE_0000 + k; step(); end
        bus.ld_dat_vld = 0; step(); step();
        e = '{32'd30, 32'd31, 32'd0, 32'd1};           chk_q("wrap_waddr", wlog, e);
        clr_logs();
        start_load(9, 0);
        chk("len0_done", bus.ld_done, 1);
        chk("len0_busy", bus.ld_busy, 0);
        step();
        chk("len0_done_off", bus.ld_done, 0);
        step();
        chk("len0_no_writes", 32'(wlog.size()), 0);
        chk("len0_done_count", n_done, 1);

        // Write collision stall
        clr_logs();
        start_load(6, 1);
        bus.ld_dat_vld = 1; bus.ld_dat = 32'h0000_0D0D;
        bus.rd_addr = {5'd0, 5'd6, 5'd0, 5'd9};
        bus.rd_req = 4'b0101;
        #1;
        chk("coll_gnt_first", bus.rd_gnt, 4'b0001);
        chk("coll_raddr_first", bus.ram_raddr, 9);
        step();
        bus.ld_dat_vld = 0; bus.rd_req = 4'b0100;
        #1;
        chk("coll_gnt_second", bus.rd_gnt, 4'b0100);
        step();
        bus.rd_req = 4'b0000;
        #1;
        chk("coll_ret_vld", bus.rd_vld, 1);
        chk("coll_ret_id", bus.rd_id, 2);
        chk("coll_ret_dat", bus.rd_dat, 32'h0000_0D0D);
        step(); step();

        // Loader stalls while reads of address 0 continue
        clr_logs();
        start_load(10, 2);
        bus.rd_addr = {5'd0, 5'd0, 5'd0, 5'd0};
        bus.rd_req = 4'b0010;
        bus.ld_dat_vld = 1; bus.ld_dat = 32'h0000_E001; step();
        bus.ld_dat_vld = 0; step();
        bus.ld_dat_vld = 1; bus.ld_dat = 32'h0000_E002; step();
        bus.ld_dat_vld = 0; step();
        bus.rd_req = 4'b0000; step(); step();
        e = '{32'd10, 32'd11};                         chk_q("stall_waddr", wlog, e);
        e = '{32'hE001, 32'hE002};                     chk_q("stall_wdat", wdlog, e);
        e = '{32'd1, 32'd1, 32'd1, 32'd1};             chk_q("stall_gnts", glog, e);
        chk("stall_ret_dat", rdat_log[0], 32'hC0DE_0002);

        // Reset in the middle of a 5-beat load
        clr_logs();
        start_load(12, 5);
        bus.rd_addr = {5'd20, 5'd0, 5'd0, 5'd0};
        bus.rd_req = 4'b1000;
        bus.ld_dat_vld = 1; bus.ld_dat = 32'h0000_F000; step();
        bus.ld_dat = 32'h0000_F001; step();
        done_before = n_done;
        rst_n = 0;
        #1;
        chk("mid_rst_busy", bus.ld_busy, 0);
        chk("mid_rst_rdy", bus.ld_dat_rdy, 0);
        chk("mid_rst_gnt", bus.rd_gnt, 0);
        chk("mid_rst_wren", bus.ram_wren, 0);
        chk("mid_rst_vld", bus.rd_vld, 0);
        step(); step();
        rst_n = 1; bus.ld_dat_vld = 0; bus.rd_req = 0;
        step();
        chk("after_rst_busy", bus.ld_busy, 0);
        chk("after_rst_no_done", n_done, done_before);
        start_load(3, 1);
        bus.ld_dat_vld = 1; bus.ld_dat = 32'h0000_1234;
        #1;
        chk("restart_busy", bus.ld_busy, 1);
        chk("restart_wraddr", bus.ram_wraddr, 3);
        step();
        bus.ld_dat_vld = 0;
        #1;
        chk("restart_done", bus.ld_done, 1);
        step(); step();
        e = '{32'd12, 32'd13, 32'd3};                  chk_q("rst_waddr", wlog, e);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
